slave_axi_s_interface: RTL and testbench

AXI4-Stream slave front end for the encoder sample path. It accepts 16-bit audio samples with frame markers (TLAST) from an upstream stream master. It buffers them in a small FIFO and presents them to the downstream encoder core on a simple VALID/READY/LAST interface. The stream is ignored until a TUSER start pulse arms the block.

---
 rtl/slave_axi_s_interface.sv | 160 ++++++++++++++++
 tb/tb_slave_axi_s_interface.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_axi_s_interface.sv
// ---------------------------------------------------------------------------
// slave_axi_s_interface
//
// AXI4-Stream slave front end for the encoder sample path. Upstream beats of
// {TLAST, TDATA} are buffered in a small circular FIFO. They are handed to the
// encoder core on a simple VALID/READY/LAST interface. The block ignores the
// stream until a TUSER pulse arms it. It stays armed until reset.
//
// Ports:
//   ACLK    in   clock, all logic on the rising edge
//   ARESET  in   synchronous active-high reset
//   TVALID  in   upstream beat valid
//   TREADY  out  block can accept a beat (armed and FIFO not full)
//   TDATA   in   upstream sample, passed through untouched
//   TLAST   in   last sample of a frame, stored per entry
//   TUSER   in   start-of-stream pulse, arms the block
//   READY   in   downstream core accepts SAMPLE
//   VALID   out  SAMPLE/LAST hold a valid FIFO head entry
//   LAST    out  current SAMPLE ends a frame (0 while VALID=0)
//   SAMPLE  out  head sample to the downstream core (registered)
// ---------------------------------------------------------------------------
module slave_axi_s_interface #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  TVALID,
   output logic                  TREADY,
   input  logic [DATA_WIDTH-1:0] TDATA,
   input  logic                  TLAST,
   input  logic                  TUSER,
   input  logic                  READY,
   output logic                  VALID,
   output logic                  LAST,
   output logic [DATA_WIDTH-1:0] SAMPLE
);

   localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
   localparam int CNT_WIDTH = PTR_WIDTH + 1;

   typedef enum logic {
      S_IDLE,
      S_ARMED
   } arm_state_t;

   arm_state_t arm_state;
   arm_state_t arm_state_next;

   logic [DATA_WIDTH:0]  fifo_mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] wr_ptr_next;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr_next;
   logic [CNT_WIDTH-1:0] count;
   logic [CNT_WIDTH-1:0] count_next;
   logic                 push;
   logic                 pop;
   logic [DATA_WIDTH:0]  head_entry;

   // Arming state register. Only reset returns the block to idle, so a
   // second TUSER pulse mid-stream is harmless.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         arm_state <= S_IDLE;
      end else begin
         arm_state <= arm_state_next;
      end
   end

   // Next arming state and TREADY. TREADY looks only at registered state
   // (arm flag and count), never at TVALID. It therefore stays low in the
   // cycle TUSER is first seen, and it stays low when full even if a pop is
   // happening in the same cycle.
   always_comb begin
      arm_state_next = arm_state;
      TREADY         = 1'b0;
      case (arm_state)
         S_IDLE: begin
            if (TUSER) begin
               arm_state_next = S_ARMED;
            end
         end
         S_ARMED: begin
            TREADY = (count < CNT_WIDTH'(FIFO_DEPTH));
         end
         default: begin
            arm_state_next = S_IDLE;
         end
      endcase
   end

   assign VALID = (count != '0);
   assign push  = TVALID && TREADY;
   assign pop   = VALID && READY;

   // Pointer and occupancy bookkeeping. Pointers are exactly log2(depth)
   // bits wide, so incrementing them wraps naturally around the buffer.
   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      count_next  = count;
      if (push) begin
         wr_ptr_next = wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr + PTR_WIDTH'(1);
      end
      if (push && !pop) begin
         count_next = count + CNT_WIDTH'(1);
      end else if (!push && pop) begin
         count_next = count - CNT_WIDTH'(1);
      end
   end

   // Work out which entry becomes the head after this edge. If the incoming
   // beat lands exactly at the next read position, the FIFO was empty apart
   // from anything being popped. The new beat is then the head. It has not
   // reached the memory yet, so it is taken straight from the inputs into
   // the output register. It still appears one cycle after acceptance.
   always_comb begin
      head_entry = fifo_mem[rd_ptr_next];
      if (push && (rd_ptr_next == wr_ptr)) begin
         head_entry = {TLAST, TDATA};
      end
   end

   // Buffer storage. This block has no reset because the pointers and count
   // define what is valid. Writes are suppressed during reset so that the
   // beat presented in a reset cycle is simply lost.
   always_ff @(posedge ACLK) begin
      if (push && !ARESET) begin
         fifo_mem[wr_ptr] <= {TLAST, TDATA};
      end
   end

   // Pointer/count registers and the registered output stage. SAMPLE keeps
   // its previous value when the FIFO drains. LAST is cleared when the FIFO
   // drains so that a frame marker never appears without VALID.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         SAMPLE <= '0;
         LAST   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         if (count_next != '0) begin
            SAMPLE <= head_entry[DATA_WIDTH-1:0];
            LAST   <= head_entry[DATA_WIDTH];
         end else begin
            LAST   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_slave_axi_s_interface.sv
// ---------------------------------------------------------------------------
// tb_slave_axi_s_interface
//
// Directed testbench for slave_axi_s_interface. Inputs change 1 ns after each
// rising ACLK edge. Outputs are checked at that same point, once they have
// settled after the edge. The test covers reset/idle, arming, streaming,
// frame markers, backpressure/full, push/pop wrap and reset in mid-stream.
// ---------------------------------------------------------------------------
module tb_slave_axi_s_interface;

   logic        ACLK;
   logic        ARESET;
   logic        TVALID;
   logic        TREADY;
   logic [15:0] TDATA;
   logic        TLAST;
   logic        TUSER;
   logic        READY;
   logic        VALID;
   logic        LAST;
   logic [15:0] SAMPLE;

   int vectors;
   int miscompares;

   logic [16:0] model_q[$];
   int          sent;

   slave_axi_s_interface #(
      .DATA_WIDTH(16),
      .FIFO_DEPTH(4)
   ) dut (
      .ACLK  (ACLK),
      .ARESET(ARESET),
      .TVALID(TVALID),
      .TREADY(TREADY),
      .TDATA (TDATA),
      .TLAST (TLAST),
      .TUSER (TUSER),
      .READY (READY),
      .VALID (VALID),
      .LAST  (LAST),
      .SAMPLE(SAMPLE)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Drive every upstream/downstream input in one go.
   task automatic applyStimulus(input logic valid, input logic [15:0] data,
                                input logic last, input logic user,
                                input logic ready);
      TVALID = valid;
      TDATA  = data;
      TLAST  = last;
      TUSER  = user;
      READY  = ready;
   endtask

   // One comparison: the observed DUT value against the expected value
   // computed by the bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and move 1 ns past the edge.
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // One cycle of the queue model used for the wrap test. The inputs must
   // already be applied. The step checks the outputs against the model,
   // predicts the accept/pop, and then clocks once.
   task automatic modelStep();
      logic exp_tready;
      logic exp_valid;
      logic do_push;
      logic do_pop;
      exp_tready = (model_q.size() < 4);
      exp_valid  = (model_q.size() != 0);
      checkOutput("wrap_tready", {31'd0, TREADY}, {31'd0, exp_tready});
      checkOutput("wrap_valid", {31'd0, VALID}, {31'd0, exp_valid});
      if (exp_valid) begin
         checkOutput("wrap_sample", {16'd0, SAMPLE}, {16'd0, model_q[0][15:0]});
         checkOutput("wrap_last", {31'd0, LAST}, {31'd0, model_q[0][16]});
      end else begin
         checkOutput("wrap_last_idle", {31'd0, LAST}, 32'd0);
      end
      do_push = TVALID && exp_tready;
      do_pop  = exp_valid && READY;
      if (do_pop) begin
         void'(model_q.pop_front());
      end
      if (do_push) begin
         model_q.push_back({TLAST, TDATA});
         sent++;
      end
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      sent        = 0;
      ARESET      = 1'b1;
      applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);

      // ---- reset / idle ----
      tick();
      tick();
      checkOutput("rst_tready", {31'd0, TREADY}, 32'd0);
      checkOutput("rst_valid", {31'd0, VALID}, 32'd0);
      checkOutput("rst_last", {31'd0, LAST}, 32'd0);
      checkOutput("rst_sample", {16'd0, SAMPLE}, 32'd0);
      ARESET = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("idle_tready", {31'd0, TREADY}, 32'd0);
         checkOutput("idle_valid", {31'd0, VALID}, 32'd0);
      end

      // ---- arming ----
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      checkOutput("arm_tready_pulse", {31'd0, TREADY}, 32'd0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      checkOutput("arm_tready_after", {31'd0, TREADY}, 32'd1);

      // ---- streaming 1..10 with READY held high ----
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
         tick();
         checkOutput("stream_valid", {31'd0, VALID}, 32'd1);
         checkOutput("stream_sample", {16'd0, SAMPLE}, i);
         checkOutput("stream_tready", {31'd0, TREADY}, 32'd1);
      end
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("stream_drain_valid", {31'd0, VALID}, 32'd0);
      checkOutput("stream_drain_sample", {16'd0, SAMPLE}, 32'd10);

      // ---- two frames of 1920 samples ----
      for (int i = 1; i <= 3840; i++) begin
         applyStimulus(1'b1, 16'(i), (i == 1920) || (i == 3840), 1'b0, 1'b1);
         tick();
         checkOutput("frame_valid", {31'd0, VALID}, 32'd1);
         checkOutput("frame_sample", {16'd0, SAMPLE}, i);
         checkOutput("frame_last", {31'd0, LAST},
                     ((i == 1920) || (i == 3840)) ? 32'd1 : 32'd0);
      end
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("frame_drain_valid", {31'd0, VALID}, 32'd0);
      checkOutput("frame_drain_last", {31'd0, LAST}, 32'd0);

      // ---- backpressure / full ----
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      checkOutput("bp_rst_tready", {31'd0, TREADY}, 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_armed", {31'd0, TREADY}, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 16'hA000 + 16'(k), k == 4, 1'b0, 1'b0);
         checkOutput("bp_accept_tready", {31'd0, TREADY}, 32'd1);
         tick();
      end
      applyStimulus(1'b1, 16'hA005, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         checkOutput("bp_full_tready", {31'd0, TREADY}, 32'd0);
         checkOutput("bp_hold_valid", {31'd0, VALID}, 32'd1);
         checkOutput("bp_hold_sample", {16'd0, SAMPLE}, 32'hA001);
         checkOutput("bp_hold_last", {31'd0, LAST}, 32'd0);
         tick();
      end
      READY = 1'b1;
      checkOutput("bp_full_pop_tready", {31'd0, TREADY}, 32'd0);
      checkOutput("bp_r0_sample", {16'd0, SAMPLE}, 32'hA001);
      tick();
      checkOutput("bp_r1_tready", {31'd0, TREADY}, 32'd1);
      checkOutput("bp_r1_sample", {16'd0, SAMPLE}, 32'hA002);
      tick();
      applyStimulus(1'b1, 16'hA006, 1'b0, 1'b0, 1'b1);
      checkOutput("bp_r2_sample", {16'd0, SAMPLE}, 32'hA003);
      checkOutput("bp_r2_tready", {31'd0, TREADY}, 32'd1);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      checkOutput("bp_r3_sample", {16'd0, SAMPLE}, 32'hA004);
      checkOutput("bp_r3_last", {31'd0, LAST}, 32'd1);
      tick();
      checkOutput("bp_r4_sample", {16'd0, SAMPLE}, 32'hA005);
      checkOutput("bp_r4_last", {31'd0, LAST}, 32'd0);
      tick();
      checkOutput("bp_r5_sample", {16'd0, SAMPLE}, 32'hA006);
      checkOutput("bp_r5_valid", {31'd0, VALID}, 32'd1);
      tick();
      checkOutput("bp_r6_valid", {31'd0, VALID}, 32'd0);
      checkOutput("bp_r6_sample", {16'd0, SAMPLE}, 32'hA006);
      checkOutput("bp_r6_last", {31'd0, LAST}, 32'd0);

      // ---- simultaneous push/pop with wrap (queue model) ----
      model_q.delete();
      applyStimulus(1'b1, 16'hB000, 1'b0, 1'b0, 1'b0);
      modelStep();
      applyStimulus(1'b1, 16'hB001, 1'b1, 1'b0, 1'b0);
      modelStep();
      sent = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if ((sent >= 20) && (model_q.size() == 0)) begin
            break;
         end
         applyStimulus(sent < 20, 16'hB002 + 16'(sent), (sent % 3) == 0,
                       1'b0, cyc[0]);
         modelStep();
      end
      checkOutput("wrap_beats_sent", sent, 32'd20);
      checkOutput("wrap_final_valid", {31'd0, VALID}, 32'd0);

      // ---- reset in mid-stream ----
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b1, 16'hC000 + 16'(k), 1'b0, 1'b0, 1'b0);
         tick();
      end
      checkOutput("mid_pre_valid", {31'd0, VALID}, 32'd1);
      checkOutput("mid_pre_sample", {16'd0, SAMPLE}, 32'hC001);
      applyStimulus(1'b1, 16'hC004, 1'b0, 1'b0, 1'b0);
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      checkOutput("mid_valid", {31'd0, VALID}, 32'd0);
      checkOutput("mid_tready", {31'd0, TREADY}, 32'd0);
      checkOutput("mid_sample", {16'd0, SAMPLE}, 32'd0);
      checkOutput("mid_last", {31'd0, LAST}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         tick();
         checkOutput("mid_unarmed_tready", {31'd0, TREADY}, 32'd0);
         checkOutput("mid_unarmed_valid", {31'd0, VALID}, 32'd0);
      end
      applyStimulus(1'b1, 16'hC005, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 16'hC005, 1'b0, 1'b0, 1'b0);
      checkOutput("rearm_tready", {31'd0, TREADY}, 32'd1);
      checkOutput("rearm_valid", {31'd0, VALID}, 32'd0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      checkOutput("rearm_out_valid", {31'd0, VALID}, 32'd1);
      checkOutput("rearm_out_sample", {16'd0, SAMPLE}, 32'hC005);
      tick();
      checkOutput("rearm_drain_valid", {31'd0, VALID}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
